// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: merges instruction (port 0) and data (port 1) memory
// request streams onto one single-ported memory and steers in-order
// responses back to their owner through a 1-bit tag FIFO.
//
// Parameters:
//   p_addr_sz       address width inside the memory message
//   p_data_sz       data width inside the memory message
//   p_max_inflight  outstanding request limit (power of two, >= 2)
//
// Ports (val/rdy handshakes, transfer when both high at posedge):
//   clk, reset                        clock, synchronous active-high reset
//   req0_msg/val/rdy                  port 0 (instruction) request
//   resp0_msg/val/rdy                 port 0 response
//   req1_msg/val/rdy                  port 1 (data) request
//   resp1_msg/val/rdy                 port 1 response
//   memreq_msg/val/rdy                merged request to memory
//   memresp_msg/val/rdy               response from memory
//
// Message layout (MSB first):
//   request  {type, addr, len, data}
//   response {type, len, data}
//
// Build option:
//   RISCV_MEM_ARB_FIXED_PRIO_EN  defined: port 1 always wins a conflict
//                                undefined: round-robin between ports

module riscv_mem_arbiter #(
  parameter int p_addr_sz      = 32,
  parameter int p_data_sz      = 32,
  parameter int p_max_inflight = 4,
  localparam int c_len_sz  = $clog2(p_data_sz / 8),
  localparam int c_req_sz  = 1 + p_addr_sz + c_len_sz + p_data_sz,
  localparam int c_resp_sz = 1 + c_len_sz + p_data_sz
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic [c_req_sz-1:0]  req0_msg,
  input  logic                 req0_val,
  output logic                 req0_rdy,

  output logic [c_resp_sz-1:0] resp0_msg,
  output logic                 resp0_val,
  input  logic                 resp0_rdy,

  input  logic [c_req_sz-1:0]  req1_msg,
  input  logic                 req1_val,
  output logic                 req1_rdy,

  output logic [c_resp_sz-1:0] resp1_msg,
  output logic                 resp1_val,
  input  logic                 resp1_rdy,

  output logic [c_req_sz-1:0]  memreq_msg,
  output logic                 memreq_val,
  input  logic                 memreq_rdy,

  input  logic [c_resp_sz-1:0] memresp_msg,
  input  logic                 memresp_val,
  output logic                 memresp_rdy
);

  localparam int c_ptr_sz = $clog2(p_max_inflight);
  localparam int c_cnt_sz = c_ptr_sz + 1;

  localparam logic [c_cnt_sz-1:0] c_full =
    c_cnt_sz'(p_max_inflight);

  // ------------------------------------------------------------------
  // Tag FIFO state
  // ------------------------------------------------------------------

  logic [p_max_inflight-1:0] tags;
  logic [c_ptr_sz-1:0]       wptr;
  logic [c_ptr_sz-1:0]       rptr;
  logic [c_cnt_sz-1:0]       count;

  logic full;
  logic empty;
  logic head;
  logic push;
  logic pop;

  assign full  = (count == c_full);
  assign empty = (count == '0);
  assign head  = tags[rptr];

  // ------------------------------------------------------------------
  // Grant selection
  // ------------------------------------------------------------------

  logic gnt0;
  logic gnt1;

`ifdef RISCV_MEM_ARB_FIXED_PRIO_EN

  assign gnt1 = req1_val;

`else

  // prio names the port that wins the next conflict
  logic prio;

  assign gnt1 = req1_val & (~req0_val | prio);

  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= 1'b0;
    end else if (push) begin
      prio <= ~gnt1;
    end
  end

`endif

  assign gnt0 = req0_val & ~gnt1;

  // ------------------------------------------------------------------
  // Request side
  // ------------------------------------------------------------------

  // full is the only FIFO term here, so memresp never reaches reqN_rdy
  logic req_ok;

  assign req_ok = ~reset & ~full;

  assign memreq_val = (req0_val | req1_val) & req_ok;
  assign req0_rdy   = gnt0 & memreq_rdy & req_ok;
  assign req1_rdy   = gnt1 & memreq_rdy & req_ok;

  always_comb begin
    memreq_msg = '0;
    if (!reset) begin
      unique case (1'b1)
        gnt0:    memreq_msg = req0_msg;
        gnt1:    memreq_msg = req1_msg;
        default: memreq_msg = '0;
      endcase
    end
  end

  assign push = memreq_val & memreq_rdy;

  // ------------------------------------------------------------------
  // Response side
  // ------------------------------------------------------------------

  logic resp_ok;
  logic head_rdy;

  assign resp_ok  = ~reset & ~empty;
  assign head_rdy = head ? resp1_rdy : resp0_rdy;

  assign resp0_msg   = memresp_msg;
  assign resp1_msg   = memresp_msg;
  assign resp0_val   = memresp_val & resp_ok & ~head;
  assign resp1_val   = memresp_val & resp_ok &  head;
  assign memresp_rdy = head_rdy & resp_ok;

  assign pop = memresp_val & memresp_rdy;

  // ------------------------------------------------------------------
  // Tag FIFO update
  // ------------------------------------------------------------------

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + c_ptr_sz'(1);
      end
      if (pop) begin
        rptr <= rptr + c_ptr_sz'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + c_cnt_sz'(1);
        2'b01:   count <= count - c_cnt_sz'(1);
        default: count <= count;
      endcase
    end
  end

  // Owner bits need no reset: count gates every read of them
  always_ff @(posedge clk) begin
    if (push) begin
      tags[wptr] <= gnt1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset && memresp_val && empty) begin
      $error("ERROR: riscv_mem_arbiter response with no outstanding request");
    end
  end
`endif

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: directed checks of riscv_mem_arbiter covering
// reset gating, round-robin, full FIFO, backpressure and wrap-around.

module tb_riscv_mem_arbiter;

  localparam int RQ = 67;
  localparam int RS = 35;

`ifdef RISCV_MEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [RQ-1:0] req0_msg;
  logic          req0_val;
  logic          req0_rdy;
  logic [RS-1:0] resp0_msg;
  logic          resp0_val;
  logic          resp0_rdy;
  logic [RQ-1:0] req1_msg;
  logic          req1_val;
  logic          req1_rdy;
  logic [RS-1:0] resp1_msg;
  logic          resp1_val;
  logic          resp1_rdy;
  logic [RQ-1:0] memreq_msg;
  logic          memreq_val;
  logic          memreq_rdy;
  logic [RS-1:0] memresp_msg;
  logic          memresp_val;
  logic          memresp_rdy;

  always #5 clk = ~clk;

  riscv_mem_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .req0_msg    (req0_msg),
    .req0_val    (req0_val),
    .req0_rdy    (req0_rdy),
    .resp0_msg   (resp0_msg),
    .resp0_val   (resp0_val),
    .resp0_rdy   (resp0_rdy),
    .req1_msg    (req1_msg),
    .req1_val    (req1_val),
    .req1_rdy    (req1_rdy),
    .resp1_msg   (resp1_msg),
    .resp1_val   (resp1_val),
    .resp1_rdy   (resp1_rdy),
    .memreq_msg  (memreq_msg),
    .memreq_val  (memreq_val),
    .memreq_rdy  (memreq_rdy),
    .memresp_msg (memresp_msg),
    .memresp_val (memresp_val),
    .memresp_rdy (memresp_rdy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag,
                     input logic [RQ-1:0] got,
                     input logic [RQ-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [RQ-1:0] mkreq(input logic [31:0] a,
                                          input logic [31:0] d);
    return {1'b0, a, 2'b00, d};
  endfunction

  function automatic logic [RS-1:0] mkresp(input logic [31:0] d);
    return {1'b0, 2'b00, d};
  endfunction

  task automatic next;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] ea;
  logic        g;
  logic        own;
  logic [RQ-1:0] addr_q;

  initial begin
    req0_msg    = mkreq(32'h100, 32'h11);
    req1_msg    = mkreq(32'h2000, 32'h22);
    req0_val    = 1'b1;
    req1_val    = 1'b1;
    memreq_rdy  = 1'b1;
    memresp_val = 1'b1;
    memresp_msg = mkresp(32'hdead);
    resp0_rdy   = 1'b1;
    resp1_rdy   = 1'b1;

    // reset held 3 cycles with everything requesting
    for (int i = 0; i < 3; i++) begin
      next();
      chk("rst_req0_rdy", RQ'(req0_rdy), '0);
      chk("rst_req1_rdy", RQ'(req1_rdy), '0);
      chk("rst_memreq_val", RQ'(memreq_val), '0);
      chk("rst_memreq_msg", memreq_msg, '0);
      chk("rst_memresp_rdy", RQ'(memresp_rdy), '0);
      chk("rst_resp0_val", RQ'(resp0_val), '0);
      chk("rst_resp1_val", RQ'(resp1_val), '0);
    end

    reset       = 1'b0;
    memresp_val = 1'b0;

    // round-robin conflict, responses one cycle behind
    for (int i = 0; i < 5; i++) begin
      req0_val    = (i < 4);
      req1_val    = (i < 4);
      memresp_val = (i > 0);
      memresp_msg = mkresp(32'hA0 + 32'(i));
      #1;
      if (i < 4) begin
        g  = 1'(i % 2);
        ea = g ? 32'h2000 : 32'h100;
        addr_q = RQ'(memreq_msg[65:34]);
        chk("rr_addr", addr_q, RQ'(ea));
        chk("rr_req0_rdy", RQ'(req0_rdy), RQ'(!g));
        chk("rr_req1_rdy", RQ'(req1_rdy), RQ'(g));
      end else begin
        chk("rr_idle_val", RQ'(memreq_val), '0);
      end
      if (i > 0) begin
        own = 1'((i - 1) % 2);
        chk("rr_resp0_val", RQ'(resp0_val), RQ'(!own));
        chk("rr_resp1_val", RQ'(resp1_val), RQ'(own));
        chk("rr_resp_msg", RQ'(own ? resp1_msg : resp0_msg),
            RQ'(mkresp(32'hA0 + 32'(i))));
      end
      next();
    end

    // fill the tag FIFO from port 1
    req0_val    = 1'b0;
    req1_val    = 1'b1;
    memresp_val = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("fill_rdy", RQ'(req1_rdy), 1);
      next();
    end
    #1;
    chk("full_rdy", RQ'(req1_rdy), '0);
    chk("full_val", RQ'(memreq_val), '0);
    next();

    // pop while full: no grant in the same cycle
    memresp_val = 1'b1;
    memresp_msg = mkresp(32'hB0);
    #1;
    chk("full_resp1_val", RQ'(resp1_val), 1);
    chk("full_memresp_rdy", RQ'(memresp_rdy), 1);
    chk("full_pop_rdy", RQ'(req1_rdy), '0);
    next();
    memresp_val = 1'b0;
    #1;
    chk("after_pop_rdy", RQ'(req1_rdy), 1);
    next();

    req1_val    = 1'b0;
    memresp_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_resp1", RQ'(resp1_val), 1);
      next();
    end
    memresp_val = 1'b0;
    #1;
    chk("drain_empty", RQ'(memresp_rdy), '0);

    // response backpressure on port 0
    req0_val = 1'b1;
    #1;
    chk("bp_req0_rdy", RQ'(req0_rdy), 1);
    next();
    req0_val    = 1'b0;
    memresp_val = 1'b1;
    resp0_rdy   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_stall_rdy", RQ'(memresp_rdy), '0);
      chk("bp_stall_val", RQ'(resp0_val), 1);
      next();
    end
    resp0_rdy = 1'b1;
    #1;
    chk("bp_go_rdy", RQ'(memresp_rdy), 1);
    chk("bp_go_val", RQ'(resp0_val), 1);
    next();
    memresp_val = 1'b0;
    #1;
    chk("bp_empty", RQ'(memresp_rdy), '0);

    // wrap-around: push and pop in the same cycle
    for (int i = 0; i < 21; i++) begin
      req0_val    = (i < 20) && (i % 2 == 0);
      req1_val    = (i < 20) && (i % 2 == 1);
      memresp_val = (i > 0);
      memresp_msg = mkresp(32'(i));
      #1;
      if (i < 20) begin
        chk("wr_rdy", RQ'((i % 2 == 1) ? req1_rdy : req0_rdy), 1);
      end
      if (i > 0) begin
        own = 1'((i - 1) % 2);
        chk("wr_resp0", RQ'(resp0_val), RQ'(!own));
        chk("wr_resp1", RQ'(resp1_val), RQ'(own));
      end
      next();
    end
    memresp_val = 1'b0;
    #1;
    chk("wr_empty", RQ'(memresp_rdy), '0);

    // memory backpressure: nothing fires, priority holds
    req0_val   = 1'b1;
    req1_val   = 1'b1;
    memreq_rdy = 1'b0;
    #1;
    chk("mbp_val", RQ'(memreq_val), 1);
    chk("mbp_req0_rdy", RQ'(req0_rdy), '0);
    chk("mbp_req1_rdy", RQ'(req1_rdy), '0);
    addr_q = RQ'(memreq_msg[65:34]);
    chk("mbp_addr", addr_q, FIXED ? RQ'(32'h2000) : RQ'(32'h100));
    next();

    // three-cycle conflict
    memreq_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      g = FIXED ? 1'b1 : 1'(i % 2);
      chk("cf_req0_rdy", RQ'(req0_rdy), RQ'(!g));
      chk("cf_req1_rdy", RQ'(req1_rdy), RQ'(g));
      next();
    end
    req0_val    = 1'b0;
    req1_val    = 1'b0;
    memresp_val = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      g = FIXED ? 1'b1 : 1'(i % 2);
      chk("cf_resp1", RQ'(resp1_val), RQ'(g));
      chk("cf_resp0", RQ'(resp0_val), RQ'(!g));
      next();
    end
    memresp_val = 1'b0;
    #1;
    chk("cf_empty", RQ'(memresp_rdy), '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
